// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller driving tag/status and line RAMs.
// Optional CACHE_STATS_EN adds hit_count/miss_count/wb_count outputs.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    core load/store request (valid/we/addr/wdata), req_ready back
//   resp_valid, resp_rdata   one-cycle completion pulse with load data
//   ram_addr                 shared index to both RAMs (1-cycle read latency)
//   st_we, tag_wdata,        tag/status RAM write port and read data
//   status_wdata,
//   tag_rdata, status_rdata
//   data_we, data_wdata,     line data RAM write port and read data
//   data_rdata
//   mem_*                    line-granular memory port (write-back / refill)
//   hit/miss/wb_count        statistics, only with CACHE_STATS_EN
module cache_ctrl #(
  parameter int unsigned tag_len    = 13,
  parameter int unsigned index_len  = 10,
  parameter int unsigned offset_len = 4,
  localparam int unsigned AW = tag_len + index_len + offset_len,
  localparam int unsigned LW = 32 << (offset_len - 2),
  localparam int unsigned WN = 1 << (offset_len - 2),
  localparam int unsigned SW = offset_len - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic                         req_we,
  input  logic [AW-1:0]                req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic [index_len-1:0]         ram_addr,
  output logic                         st_we,
  output logic [tag_len-1:0]           tag_wdata,
  output logic [2:0]                   status_wdata,
  input  logic [tag_len-1:0]           tag_rdata,
  input  logic [2:0]                   status_rdata,
  output logic                         data_we,
  output logic [LW-1:0]                data_wdata,
  input  logic [LW-1:0]                data_rdata,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [tag_len+index_len-1:0] mem_addr,
  output logic [LW-1:0]                mem_wdata,
  input  logic                         mem_ack,
  input  logic                         mem_rvalid,
  input  logic [LW-1:0]                mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
  output logic [31:0]                  wb_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_FILL_WAIT,
    S_WRITE,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [tag_len-1:0]   tag_q, tag_d;
  logic [index_len-1:0] idx_q, idx_d;
  logic [SW-1:0]        wsel_q, wsel_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [LW-1:0]        line_q, line_d;
  logic [tag_len-1:0]   vtag_q, vtag_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [tag_len-1:0]   req_tag;
  logic [index_len-1:0] req_idx;
  logic [SW-1:0]        req_wsel;
  logic                 hit;
  logic                 victim_dirty;
  logic                 unused_bits;

  assign req_tag  = req_addr[AW-1 -: tag_len];
  assign req_idx  = req_addr[offset_len +: index_len];
  assign req_wsel = req_addr[2 +: SW];

  // Byte lane bits and the reserved status bit carry no information.
  assign unused_bits = ^{req_addr[1:0], status_rdata[2]};

  // RAM outputs in LOOKUP belong to the index presented in IDLE.
  assign hit          = status_rdata[0] && (tag_rdata == tag_q);
  assign victim_dirty = status_rdata[0] && status_rdata[1];

  assign resp_rdata = rdata_q;

  function automatic logic [31:0] word_of(
    input logic [LW-1:0] line,
    input logic [SW-1:0] sel
  );
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < int'(WN); i++) begin
      if (sel == SW'(i)) begin
        w = line[i*32 +: 32];
      end
    end
    return w;
  endfunction

  function automatic logic [LW-1:0] merge(
    input logic [LW-1:0] line,
    input logic [SW-1:0] sel,
    input logic [31:0]   wd
  );
    logic [LW-1:0] r;
    r = line;
    for (int i = 0; i < int'(WN); i++) begin
      if (sel == SW'(i)) begin
        r[i*32 +: 32] = wd;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    vtag_d  = vtag_q;
    rdata_d = rdata_q;

    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    ram_addr     = idx_q;
    st_we        = 1'b0;
    data_we      = 1'b0;
    tag_wdata    = tag_q;
    status_wdata = {1'b0, we_q, 1'b1};
    data_wdata   = line_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {tag_q, idx_q};
    mem_wdata    = line_q;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        // Present the index now so tag/data arrive in LOOKUP.
        ram_addr  = req_valid ? req_idx : '0;
        if (req_valid) begin
          we_d    = req_we;
          tag_d   = req_tag;
          idx_d   = req_idx;
          wsel_d  = req_wsel;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        vtag_d = tag_rdata;
        if (hit) begin
          if (we_q) begin
            line_d  = merge(data_rdata, wsel_q, wdata_q);
            state_d = S_WRITE;
          end else begin
            rdata_d = word_of(data_rdata, wsel_q);
            state_d = S_RESP;
          end
        end else begin
          // Keep the victim line for a possible write-back.
          line_d  = data_rdata;
          state_d = victim_dirty ? S_WB : S_FILL;
        end
      end

      S_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {vtag_q, idx_q};
        if (mem_ack) begin
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = S_FILL_WAIT;
        end
      end

      S_FILL_WAIT: begin
        if (mem_rvalid) begin
          line_d  = we_q ? merge(mem_rdata, wsel_q, wdata_q)
                         : mem_rdata;
          rdata_d = word_of(mem_rdata, wsel_q);
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        st_we   = 1'b1;
        data_we = 1'b1;
        state_d = S_RESP;
      end

      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      tag_q   <= '0;
      idx_q   <= '0;
      wsel_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      vtag_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      vtag_q  <= vtag_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == S_LOOKUP && hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == S_LOOKUP && !hit) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (state_q == S_WB && mem_ack) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: RAM and memory-side models, golden word memory,
// per-cycle compare process and directed scenarios.
module tb_cache_ctrl;
  localparam int TL = 13;
  localparam int IL = 10;
  localparam int OL = 4;
  localparam int AW = 27;
  localparam int LW = 128;
  localparam int LA = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [IL-1:0] ram_addr;
  logic          st_we;
  logic [TL-1:0] tag_wdata;
  logic [2:0]    status_wdata;
  logic [TL-1:0] tag_rdata;
  logic [2:0]    status_rdata;
  logic          data_we;
  logic [LW-1:0] data_wdata;
  logic [LW-1:0] data_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [LA-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [LW-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
  logic [31:0]   wb_count;
`endif

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr),
    .st_we(st_we), .tag_wdata(tag_wdata),
    .status_wdata(status_wdata),
    .tag_rdata(tag_rdata), .status_rdata(status_rdata),
    .data_we(data_we), .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
`endif
  );

  // Tag/status and data RAMs, 1-cycle read latency, contents survive reset.
  bit [2:0]    st_mem [1024];
  bit [TL-1:0] tg_mem [1024];
  bit [LW-1:0] dt_mem [1024];

  always @(posedge clk) begin
    status_rdata <= st_mem[ram_addr];
    tag_rdata    <= tg_mem[ram_addr];
    data_rdata   <= dt_mem[ram_addr];
    if (st_we) begin
      st_mem[ram_addr] <= status_wdata;
      tg_mem[ram_addr] <= tag_wdata;
    end
    if (data_we) dt_mem[ram_addr] <= data_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Backing memory and golden word memory.
  logic [LW-1:0] mainmem [int unsigned];
  logic [31:0]   gold    [int unsigned];

  function automatic logic [31:0] pat_word(input int unsigned wa);
    logic [31:0] r;
    r[31:16] = 16'(wa >> 2);
    r[15:0]  = 16'(wa & 3);
    return r;
  endfunction

  function automatic logic [31:0] gword(input int unsigned wa);
    if (gold.exists(wa)) return gold[wa];
    return pat_word(wa);
  endfunction

  function automatic logic [LW-1:0] gline(input int unsigned la);
    logic [LW-1:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = gword(la*4 + w);
    return r;
  endfunction

  function automatic logic [LW-1:0] mline(input int unsigned la);
    logic [LW-1:0] r;
    if (mainmem.exists(la)) return mainmem[la];
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = pat_word(la*4 + w);
    return r;
  endfunction

  // Memory side responder.
  int ack_delay = 0;
  int rv_delay  = 1;

  initial begin : mem_side
    int wcnt;
    int rvcnt;
    bit rvp;
    logic [LA-1:0] rva;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    wcnt = 0; rvcnt = 0; rvp = 0; rva = '0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      mem_rvalid = 0;
      if (rvp) begin
        if (rvcnt == 0) begin
          mem_rvalid = 1;
          mem_rdata = mline(rva);
          rvp = 0;
        end else rvcnt--;
      end
      if (mem_req && !rst) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1;
          wcnt = 0;
          if (mem_we) mainmem[mem_addr] = mem_wdata;
          else begin
            rvp = 1; rvcnt = rv_delay; rva = mem_addr;
          end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Event counters owned by the posedge monitor.
  int cyc = 0;
  int wb_acks = 0;
  int fill_acks = 0;
  int wb_cyc = 0;
  logic [LA-1:0] last_wb_addr, last_fill_addr;
  logic [LW-1:0] last_wb_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && mem_req && mem_we) wb_cyc <= wb_cyc + 1;
    if (!rst && mem_req && mem_ack) begin
      if (mem_we) begin
        wb_acks <= wb_acks + 1;
        last_wb_addr <= mem_addr;
        last_wb_data <= mem_wdata;
      end else begin
        fill_acks <= fill_acks + 1;
        last_fill_addr <= mem_addr;
      end
    end
  end

  // Expectations for the request in flight.
  bit            active = 0;
  bit            e_we, e_hit, e_wb, e_wr;
  int            e_lat;
  int            acc_cyc;
  logic [IL-1:0] e_idx;
  logic [TL-1:0] e_tag;
  logic [31:0]   e_rd;
  logic [2:0]    e_status;
  logic [LW-1:0] e_line, e_wb_line;
  logic [LA-1:0] e_wb_la, e_fill_la;
  int            e_hits = 0, e_misses = 0, e_wbs = 0;

  // Model cache directory.
  bit          mv [1024];
  bit          md [1024];
  bit [TL-1:0] mt [1024];

  int          n_resp = 0;
  int          n_write = 0;
  logic [31:0] last_rdata;
  logic [2:0]  last_status;
  logic [LW-1:0] last_line;

  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        n_resp++;
        last_rdata = resp_rdata;
        if (!active) bad("resp_unexpected");
        else begin
          if (!e_we) chk("resp_rdata", LW'(resp_rdata), LW'(e_rd));
          if (e_lat > 0)
            chk("resp_latency", LW'(cyc - acc_cyc), LW'(e_lat));
        end
      end
      if (st_we || data_we) begin
        n_write++;
        if (!active || !e_wr) bad("ram_write_unexpected");
        else begin
          chk("st_we", LW'(st_we), LW'(1));
          chk("data_we", LW'(data_we), LW'(1));
          chk("ram_addr", LW'(ram_addr), LW'(e_idx));
          chk("tag_wdata", LW'(tag_wdata), LW'(e_tag));
          chk("status_wdata", LW'(status_wdata), LW'(e_status));
          chk("data_wdata", data_wdata, e_line);
          last_status = status_wdata;
          last_line = data_wdata;
        end
      end
      if (mem_req) begin
        if (!active) bad("mem_req_unexpected");
        else if (mem_we) begin
          if (!e_wb) bad("wb_unexpected");
          else begin
            chk("wb_addr", LW'(mem_addr), LW'(e_wb_la));
            chk("wb_data", mem_wdata, e_wb_line);
          end
        end else begin
          if (e_hit) bad("fill_unexpected");
          else chk("fill_addr", LW'(mem_addr), LW'(e_fill_la));
        end
      end
    end
  end

  int base_resp, base_write, base_wb, base_fill;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a,
                       input logic [31:0] wd);
    int unsigned la, wa, idx;
    logic [TL-1:0] tg;
    int t;
    tg = a[AW-1 -: TL];
    idx = a[OL +: IL];
    wa = a >> 2;
    la = a >> OL;
    t = 0;
    while (!req_ready && t < 100) begin tick(); t++; end
    if (!req_ready) bad("req_ready_timeout");
    e_hit = mv[idx] && (mt[idx] == tg);
    e_we = we;
    e_idx = idx[IL-1:0];
    e_tag = tg;
    e_lat = e_hit ? (we ? 3 : 2) : 0;
    e_wb = !e_hit && mv[idx] && md[idx];
    e_wb_la = {mt[idx], idx[IL-1:0]};
    e_wb_line = gline(e_wb_la);
    e_fill_la = la[LA-1:0];
    if (we) gold[wa] = wd;
    e_rd = gword(wa);
    e_wr = we || !e_hit;
    e_status = we ? 3'b011 : 3'b001;
    e_line = gline(la);
    if (e_hit) e_hits++; else e_misses++;
    if (e_wb) e_wbs++;
    base_resp = n_resp;
    base_write = n_write;
    base_wb = wb_acks;
    base_fill = fill_acks;
    active = 1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd;
    acc_cyc = cyc;
    tick();
    req_valid = 0;
  endtask

  task automatic finish_req();
    int t;
    int unsigned idx;
    t = 0;
    while (n_resp == base_resp && t < 300) begin tick(); t++; end
    if (n_resp == base_resp) bad("resp_timeout");
    tick();
    chk("ready_after_resp", LW'(req_ready), LW'(1));
    chk("resp_count", LW'(n_resp - base_resp), LW'(1));
    chk("write_count", LW'(n_write - base_write), LW'(e_wr));
    chk("wb_count_seen", LW'(wb_acks - base_wb), LW'(e_wb));
    chk("fill_count_seen", LW'(fill_acks - base_fill), LW'(!e_hit));
`ifdef CACHE_STATS_EN
    chk("hit_count", LW'(hit_count), LW'(e_hits));
    chk("miss_count", LW'(miss_count), LW'(e_misses));
    chk("wb_count", LW'(wb_count), LW'(e_wbs));
`endif
    idx = e_idx;
    md[idx] = e_we || (e_hit && md[idx]);
    mv[idx] = 1;
    mt[idx] = e_tag;
    active = 0;
  endtask

  task automatic access(input bit we, input logic [AW-1:0] a,
                        input logic [31:0] wd);
    issue(we, a, wd);
    finish_req();
  endtask

  initial begin : guard
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    int wb0;
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    mainmem[1] = 128'h88887777_66665555_44443333_22221111;
    gold[4] = 32'h22221111; gold[5] = 32'h44443333;
    gold[6] = 32'h66665555; gold[7] = 32'h88887777;
    repeat (3) tick();
    chk("rst_req_ready", LW'(req_ready), LW'(1));
    chk("rst_resp_valid", LW'(resp_valid), LW'(0));
    chk("rst_resp_rdata", LW'(resp_rdata), LW'(0));
    chk("rst_st_we", LW'(st_we), LW'(0));
    chk("rst_data_we", LW'(data_we), LW'(0));
    chk("rst_mem_req", LW'(mem_req), LW'(0));
    chk("rst_mem_we", LW'(mem_we), LW'(0));
    chk("rst_ram_addr", LW'(ram_addr), LW'(0));
    rst = 0;
    tick();

    // Cold load miss.
    access(0, 27'h0000010, 32'h0);
    chk("cold_rdata", LW'(last_rdata), LW'(32'h22221111));
    chk("cold_fill_addr", LW'(last_fill_addr), LW'(23'h000001));
    chk("cold_status", LW'(last_status), LW'(3'b001));

    // Load hit, same word.
    access(0, 27'h0000010, 32'h0);
    chk("hit_rdata", LW'(last_rdata), LW'(32'h22221111));

    // Store hit to word 1.
    access(1, 27'h0000014, 32'hDEADBEEF);
    chk("st_status", LW'(last_status), LW'(3'b011));
    chk("st_line", last_line,
        128'h88887777_66665555_DEADBEEF_22221111);

    access(0, 27'h0000014, 32'h0);
    chk("st_readback", LW'(last_rdata), LW'(32'hDEADBEEF));
    access(0, 27'h000001C, 32'h0);
    chk("hit_word3", LW'(last_rdata), LW'(32'h88887777));

    // Conflict miss with dirty victim.
    access(0, 27'h0400010, 32'h0);
    chk("wb_addr_lit", LW'(last_wb_addr), LW'(23'h000001));
    chk("wb_data_lit", last_wb_data,
        128'h88887777_66665555_DEADBEEF_22221111);
    chk("conf_fill_addr", LW'(last_fill_addr), LW'(23'h040001));
    chk("conf_rdata", LW'(last_rdata), LW'(32'h00010000));

    // Refill of the written-back line returns the stored word.
    access(0, 27'h0000014, 32'h0);
    chk("refetch_rdata", LW'(last_rdata), LW'(32'hDEADBEEF));

    // Reset while waiting for refill data.
    rv_delay = 8;
    issue(0, 27'h0800020, 32'h0);
    t = 0;
    while (fill_acks == base_fill && t < 100) begin tick(); t++; end
    if (fill_acks == base_fill) bad("abort_fill_timeout");
    tick();
    rst = 1;
    tick();
    rst = 0;
    active = 0;
    e_hits = 0; e_misses = 0; e_wbs = 0;
    base_write = n_write;
    for (int i = 0; i < 12; i++) begin
      if (!req_ready) bad("abort_ready");
      if (resp_valid) bad("abort_resp");
      if (mem_req) bad("abort_mem_req");
      tick();
    end
    chk("abort_no_write", LW'(n_write - base_write), LW'(0));
    rv_delay = 1;
    access(0, 27'h0800020, 32'h0);
    chk("after_abort_rdata", LW'(last_rdata), LW'(32'h00020000));

    // Store miss makes index 3 dirty, then delayed-ack write-back.
    access(1, 27'h0800034, 32'hCAFEF00D);
    chk("stmiss_status", LW'(last_status), LW'(3'b011));
    ack_delay = 5;
    wb0 = wb_cyc;
    access(0, 27'h0C00030, 32'h0);
    chk("wb_hold_cycles", LW'(wb_cyc - wb0), LW'(6));
    chk("wb2_addr_lit", LW'(last_wb_addr), LW'(23'h080003));
    chk("wb2_data_lit", last_wb_data,
        128'h00030003_00030002_CAFEF00D_00030000);
`ifdef CACHE_STATS_EN
    chk("stats_wb_lit", LW'(wb_count), LW'(1));
`endif
    ack_delay = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
